// File: rtl/dma_ci_controller.sv
// Bus-master DMA engine beside the CI scratch RAM: moves blocks of 32-bit words between
// system memory and RAM port B, configured and polled through the custom-instruction port.
module dma_ci_controller #(
  parameter logic [7:0] customId = 8'h00,
  parameter int         maxBurst = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic [31:0] result,
  output logic        done,
  output logic [8:0]  ramAddress,
  output logic        ramWriteEnable,
  output logic [31:0] ramWriteData,
  input  logic [31:0] ramReadData,
  output logic        busRequest,
  input  logic        busGrant,
  output logic [31:0] busAddressData,
  output logic        busBeginTransaction,
  output logic        busEndTransaction,
  output logic        busReadNotWrite,
  output logic [7:0]  busBurstSize,
  output logic [3:0]  busByteEnables,
  output logic        busDataValid,
  input  logic [31:0] busDataIn,
  input  logic        busDataValidIn,
  input  logic        busBusyIn,
  input  logic        busErrorIn,
  input  logic        busEndTransactionIn
);
  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_BEGIN, S_READ, S_WRITE, S_END, S_NEXT
  } state_t;

  localparam logic [7:0] BURST_CAP = 8'(maxBurst - 1);

  state_t      state_reg;
  logic [31:0] cfg_bus_addr_reg;
  logic [8:0]  cfg_ram_addr_reg;
  logic [9:0]  cfg_block_size_reg;
  logic [7:0]  cfg_burst_reg;
  logic        error_reg;
  logic        dir_read_reg;
  logic [31:0] bus_addr_reg;
  logic [8:0]  ram_addr_reg;
  logic [9:0]  remaining_reg;
  logic [9:0]  beat_len_reg;
  logic [9:0]  beat_cnt_reg;

  logic [2:0]  ci_sel;
  logic        ci_hit;
  logic        ci_write;
  logic        busy;
  logic        in_txn;
  logic [31:0] read_mux;
  logic [9:0]  burst_words;
  logic [9:0]  next_len;
  logic        unused_value_a;

  assign ci_sel         = valueA[12:10];
  assign ci_hit         = start && (ciN == customId) && (ci_sel != 3'd0) && (ci_sel <= 3'd5);
  assign ci_write       = ci_hit && valueA[9];
  assign busy           = (state_reg != S_IDLE);
  assign in_txn         = state_reg inside {S_BEGIN, S_READ, S_WRITE, S_END};
  assign burst_words    = {2'd0, cfg_burst_reg} + 10'd1;
  assign next_len       = (remaining_reg < burst_words) ? remaining_reg : burst_words;
  assign unused_value_a = ^{valueA[31:13], valueA[8:0]};

  always_comb begin
    read_mux = '0;
    case (ci_sel)
      3'd1:    read_mux = cfg_bus_addr_reg;
      3'd2:    read_mux = {23'd0, cfg_ram_addr_reg};
      3'd3:    read_mux = {22'd0, cfg_block_size_reg};
      3'd4:    read_mux = {24'd0, cfg_burst_reg};
      3'd5:    read_mux = {30'd0, error_reg, busy};
      default: read_mux = '0;
    endcase
  end

  // Bus strobes are decoded straight from the state register so that an async
  // reset or an error return to IDLE drops them without waiting for another edge.
  assign busRequest          = state_reg inside {S_REQUEST, S_BEGIN, S_READ, S_WRITE, S_END};
  assign busBeginTransaction = (state_reg == S_BEGIN);
  assign busEndTransaction   = (state_reg == S_END);
  assign busReadNotWrite     = in_txn && dir_read_reg;
  assign busByteEnables      = in_txn ? 4'hF : 4'h0;
  assign busBurstSize        = (state_reg == S_BEGIN) ? 8'(beat_len_reg - 10'd1) : 8'd0;
  assign busDataValid        = (state_reg == S_WRITE);
  assign busAddressData      = (state_reg == S_BEGIN) ? bus_addr_reg :
                               (state_reg == S_WRITE) ? ramReadData : 32'd0;
  assign ramWriteEnable      = (state_reg == S_READ) && busDataValidIn;
  assign ramWriteData        = ramWriteEnable ? busDataIn : 32'd0;
  // Look one word ahead whenever the current write beat is accepted, so the RAM's
  // one-cycle latency lines the next word up with the next beat; a stall re-reads.
  assign ramAddress          = !busy ? 9'd0 :
                               ((state_reg == S_WRITE) && !busBusyIn) ? ram_addr_reg + 9'd1 :
                               ram_addr_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      cfg_bus_addr_reg   <= '0;
      cfg_ram_addr_reg   <= '0;
      cfg_block_size_reg <= '0;
      cfg_burst_reg      <= '0;
      error_reg          <= 1'b0;
      dir_read_reg       <= 1'b0;
      bus_addr_reg       <= '0;
      ram_addr_reg       <= '0;
      remaining_reg      <= '0;
      beat_len_reg       <= '0;
      beat_cnt_reg       <= '0;
      done               <= 1'b0;
      result             <= '0;
    end else begin
      done   <= ci_hit;
      result <= (ci_hit && !valueA[9]) ? read_mux : 32'd0;

      if (ci_write && !busy) begin
        case (ci_sel)
          3'd1: cfg_bus_addr_reg   <= {valueB[31:2], 2'b00};
          3'd2: cfg_ram_addr_reg   <= valueB[8:0];
          3'd3: cfg_block_size_reg <= (valueB[9:0] > 10'd512) ? 10'd512 : valueB[9:0];
          3'd4: cfg_burst_reg      <= (valueB[7:0] > BURST_CAP) ? BURST_CAP : valueB[7:0];
          3'd5: begin
            error_reg <= 1'b0;
            if ((valueB[1:0] == 2'd1 || valueB[1:0] == 2'd2) && cfg_block_size_reg != 10'd0) begin
              state_reg     <= S_REQUEST;
              dir_read_reg  <= (valueB[1:0] == 2'd1);
              bus_addr_reg  <= cfg_bus_addr_reg;
              ram_addr_reg  <= cfg_ram_addr_reg;
              remaining_reg <= cfg_block_size_reg;
            end
          end
          default: ;
        endcase
      end

      case (state_reg)
        S_REQUEST: begin
          if (busGrant) begin
            state_reg    <= S_BEGIN;
            beat_len_reg <= next_len;
            beat_cnt_reg <= next_len;
          end
        end
        S_BEGIN: state_reg <= dir_read_reg ? S_READ : S_WRITE;
        S_READ: begin
          if (busDataValidIn) begin
            ram_addr_reg <= ram_addr_reg + 9'd1;
            bus_addr_reg <= bus_addr_reg + 32'd4;
          end
          if (busEndTransactionIn) state_reg <= S_NEXT;
        end
        S_WRITE: begin
          if (!busBusyIn) begin
            ram_addr_reg <= ram_addr_reg + 9'd1;
            bus_addr_reg <= bus_addr_reg + 32'd4;
            beat_cnt_reg <= beat_cnt_reg - 10'd1;
            if (beat_cnt_reg == 10'd1) state_reg <= S_END;
          end
        end
        S_END: state_reg <= S_NEXT;
        S_NEXT: begin
          remaining_reg <= remaining_reg - beat_len_reg;
          state_reg     <= (remaining_reg == beat_len_reg) ? S_IDLE : S_REQUEST;
        end
        default: ;
      endcase

      if (busErrorIn && busy) begin
        error_reg <= 1'b1;
        state_reg <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dma_ci_controller.sv
// Directed bench for dma_ci_controller: CI register access, read/write bursts,
// slave stalls, errors and reset, with a simple port-B RAM model.
module tb_dma_ci_controller;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] valueA, valueB;
  logic [7:0]  ciN;
  logic [31:0] result;
  logic        done;
  logic [8:0]  ramAddress;
  logic        ramWriteEnable;
  logic [31:0] ramWriteData, ramReadData;
  logic        busRequest, busGrant;
  logic [31:0] busAddressData;
  logic        busBeginTransaction, busEndTransaction, busReadNotWrite;
  logic [7:0]  busBurstSize;
  logic [3:0]  busByteEnables;
  logic        busDataValid;
  logic [31:0] busDataIn;
  logic        busDataValidIn, busBusyIn, busErrorIn, busEndTransactionIn;

  int checks = 0;
  int fails  = 0;
  logic [31:0] mem [0:511];
  logic [31:0] wexp [8];
  logic        wbusy [8];

  dma_ci_controller #(.customId(8'h00), .maxBurst(16)) dut (
    .clock(clock), .reset(reset), .start(start), .valueA(valueA), .valueB(valueB),
    .ciN(ciN), .result(result), .done(done), .ramAddress(ramAddress),
    .ramWriteEnable(ramWriteEnable), .ramWriteData(ramWriteData), .ramReadData(ramReadData),
    .busRequest(busRequest), .busGrant(busGrant), .busAddressData(busAddressData),
    .busBeginTransaction(busBeginTransaction), .busEndTransaction(busEndTransaction),
    .busReadNotWrite(busReadNotWrite), .busBurstSize(busBurstSize),
    .busByteEnables(busByteEnables), .busDataValid(busDataValid), .busDataIn(busDataIn),
    .busDataValidIn(busDataValidIn), .busBusyIn(busBusyIn), .busErrorIn(busErrorIn),
    .busEndTransactionIn(busEndTransactionIn)
  );

  always #5 clock = ~clock;

  // Port-B scratch RAM: synchronous write, one-cycle registered read
  always @(posedge clock) begin
    if (ramWriteEnable) mem[ramAddress] <= ramWriteData;
    ramReadData <= mem[ramAddress];
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic ci_access(input logic [7:0] op, input logic [2:0] sel, input logic we,
                           input logic [31:0] data, output logic [31:0] res,
                           output logic [31:0] res_early, output logic dn, output logic dn_early);
    cyc(); start = 1'b1; ciN = op; valueA = {19'd0, sel, we, 9'd0}; valueB = data;
    sample(); dn_early = done; res_early = result;
    cyc(); start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0;
    sample(); dn = done; res = result;
    $display("ci op=%h sel=%0d we=%0b wdata=%h -> done=%0b result=%h", op, sel, we, data, dn, res);
  endtask

  task automatic ci_rd(input logic [2:0] sel, output logic [31:0] res);
    logic [31:0] re; logic d, de;
    ci_access(8'h00, sel, 1'b0, 32'd0, res, re, d, de);
    checks++; if (d !== 1'b1 || de !== 1'b0) begin fails++; $display("FAIL ci_rd%0d_done: got %0b%0b expected 01", sel, de, d); end
    checks++; if (re !== 32'd0) begin fails++; $display("FAIL ci_rd%0d_result_early: got %h expected 0", sel, re); end
  endtask

  task automatic ci_wr(input logic [2:0] sel, input logic [31:0] data);
    logic [31:0] r, re; logic d, de;
    ci_access(8'h00, sel, 1'b1, data, r, re, d, de);
    checks++; if (d !== 1'b1 || de !== 1'b0) begin fails++; $display("FAIL ci_wr%0d_done: got %0b%0b expected 01", sel, de, d); end
  endtask

  task automatic wait_request(input string tag);
    int n = 0;
    do begin cyc(); sample(); n++; end while (busRequest !== 1'b1 && n < 20);
    checks++; if (busRequest !== 1'b1) begin fails++; $display("FAIL %s_request: got %0b expected 1", tag, busRequest); end
  endtask

  task automatic grant_begin(input string tag, input logic [31:0] addr, input logic [7:0] bsz, input logic rnw);
    cyc(); busGrant = 1'b1;
    cyc(); busGrant = 1'b0;
    sample();
    $display("burst %s begin=%0b addr=%h size=%0d rnw=%0b", tag, busBeginTransaction, busAddressData, busBurstSize, busReadNotWrite);
    checks++; if (busBeginTransaction !== 1'b1) begin fails++; $display("FAIL %s_begin: got %0b expected 1", tag, busBeginTransaction); end
    checks++; if (busAddressData !== addr) begin fails++; $display("FAIL %s_addr: got %h expected %h", tag, busAddressData, addr); end
    checks++; if (busBurstSize !== bsz) begin fails++; $display("FAIL %s_bsize: got %0d expected %0d", tag, busBurstSize, bsz); end
    checks++; if (busReadNotWrite !== rnw) begin fails++; $display("FAIL %s_rnw: got %0b expected %0b", tag, busReadNotWrite, rnw); end
    checks++; if (busByteEnables !== 4'hF) begin fails++; $display("FAIL %s_be: got %h expected f", tag, busByteEnables); end
  endtask

  task automatic read_beats(input string tag, input logic [8:0] ram_first, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(); busDataValidIn = 1'b1; busDataIn = base + 32'(k); busEndTransactionIn = (k == n - 1);
      sample();
      checks++; if (ramWriteEnable !== 1'b1 || ramAddress !== ram_first + 9'(k) || ramWriteData !== base + 32'(k)) begin
        fails++; $display("FAIL %s_beat%0d: got we=%0b a=%0d d=%h expected we=1 a=%0d d=%h", tag, k,
                          ramWriteEnable, ramAddress, ramWriteData, ram_first + 9'(k), base + 32'(k));
      end
    end
    cyc(); busDataValidIn = 1'b0; busDataIn = '0; busEndTransactionIn = 1'b0;
    sample();
    checks++; if (busRequest !== 1'b0) begin fails++; $display("FAIL %s_next_drop: got %0b expected 0", tag, busRequest); end
  endtask

  task automatic write_beats(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(); busBusyIn = wbusy[k];
      sample();
      checks++; if (busDataValid !== 1'b1 || busAddressData !== wexp[k]) begin
        fails++; $display("FAIL %s_cycle%0d: got v=%0b d=%h expected v=1 d=%h", tag, k, busDataValid, busAddressData, wexp[k]);
      end
    end
    cyc(); busBusyIn = 1'b0;
    sample();
    checks++; if (busEndTransaction !== 1'b1 || busDataValid !== 1'b0) begin
      fails++; $display("FAIL %s_end: got end=%0b v=%0b expected end=1 v=0", tag, busEndTransaction, busDataValid);
    end
    cyc(); sample();
    checks++; if (busRequest !== 1'b0) begin fails++; $display("FAIL %s_next_drop: got %0b expected 0", tag, busRequest); end
  endtask

  task automatic config_xfer(input logic [31:0] ba, input logic [31:0] ra, input logic [31:0] sz,
                             input logic [31:0] bs, input logic [31:0] ctl);
    ci_wr(3'd1, ba); ci_wr(3'd2, ra); ci_wr(3'd3, sz); ci_wr(3'd4, bs); ci_wr(3'd5, ctl);
  endtask

  task automatic test_reset();
    logic [31:0] r, re; logic d, de;
    repeat (2) cyc();
    sample();
    checks++; if (busRequest !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      fails++; $display("FAIL rst_out: got req=%0b done=%0b res=%h expected 0", busRequest, done, result); end
    checks++; if (ramWriteEnable !== 1'b0 || ramAddress !== 9'd0 || busByteEnables !== 4'h0 || busAddressData !== 32'd0) begin
      fails++; $display("FAIL rst_bus: got we=%0b a=%0d be=%h ad=%h expected 0", ramWriteEnable, ramAddress, busByteEnables, busAddressData); end
    cyc(); reset = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      ci_rd(3'(s), r);
      checks++; if (r !== 32'd0) begin fails++; $display("FAIL rst_reg%0d: got %h expected 0", s, r); end
    end
    ci_access(8'h01, 3'd1, 1'b0, 32'd0, r, re, d, de);
    checks++; if (d !== 1'b0 || r !== 32'd0) begin fails++; $display("FAIL wrong_opcode: got done=%0b res=%h expected 0", d, r); end
    ci_access(8'h00, 3'd0, 1'b0, 32'd0, r, re, d, de);
    checks++; if (d !== 1'b0) begin fails++; $display("FAIL sel0_ignored: got done=%0b expected 0", d); end
    ci_access(8'h00, 3'd6, 1'b0, 32'd0, r, re, d, de);
    checks++; if (d !== 1'b0) begin fails++; $display("FAIL sel6_ignored: got done=%0b expected 0", d); end
  endtask

  task automatic test_registers();
    logic [31:0] r;
    ci_wr(3'd1, 32'h1234_5677); ci_rd(3'd1, r);
    checks++; if (r !== 32'h1234_5674) begin fails++; $display("FAIL reg_busaddr: got %h expected 12345674", r); end
    ci_wr(3'd2, 32'h0000_03FF); ci_rd(3'd2, r);
    checks++; if (r !== 32'h1FF) begin fails++; $display("FAIL reg_ramaddr: got %h expected 1ff", r); end
    ci_wr(3'd3, 32'h0000_03FF); ci_rd(3'd3, r);
    checks++; if (r !== 32'h200) begin fails++; $display("FAIL reg_blocksize_clip: got %h expected 200", r); end
    ci_wr(3'd4, 32'd200); ci_rd(3'd4, r);
    checks++; if (r !== 32'd15) begin fails++; $display("FAIL reg_burst_clip: got %0d expected 15", r); end
    ci_wr(3'd4, 32'd7); ci_rd(3'd4, r);
    checks++; if (r !== 32'd7) begin fails++; $display("FAIL reg_burst: got %0d expected 7", r); end
  endtask

  task automatic test_bus_to_ram();
    logic [31:0] r;
    config_xfer(32'h1000, 32'd0, 32'd8, 32'd3, 32'd1);
    checks++; if (busRequest !== 1'b1) begin fails++; $display("FAIL rd_start_req: got %0b expected 1", busRequest); end
    ci_wr(3'd3, 32'd99);
    ci_rd(3'd5, r);
    checks++; if (r !== 32'h1) begin fails++; $display("FAIL rd_status_busy: got %h expected 1", r); end
    wait_request("rd_b1"); grant_begin("rd_b1", 32'h1000, 8'd3, 1'b1); read_beats("rd_b1", 9'd0, 32'hA0, 4);
    wait_request("rd_b2"); grant_begin("rd_b2", 32'h1010, 8'd3, 1'b1); read_beats("rd_b2", 9'd4, 32'hA4, 4);
    ci_rd(3'd5, r);
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL rd_status_done: got %h expected 0", r); end
    ci_rd(3'd3, r);
    checks++; if (r !== 32'd8) begin fails++; $display("FAIL rd_busy_write_ignored: got %0d expected 8", r); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL rd_ram%0d: got %h expected %h", i, mem[i], 32'hA0 + 32'(i)); end
    end
  endtask

  task automatic test_ram_to_bus_wrap();
    logic [31:0] r;
    mem[510] = 32'h5100_0510; mem[511] = 32'h5100_0511; mem[0] = 32'h5100_0000; mem[1] = 32'h5100_0001;
    wexp[0] = 32'h5100_0510; wexp[1] = 32'h5100_0511; wexp[2] = 32'h5100_0000; wexp[3] = 32'h5100_0001;
    for (int i = 0; i < 8; i++) wbusy[i] = 1'b0;
    config_xfer(32'h2000, 32'd510, 32'd4, 32'd3, 32'd2);
    wait_request("wr_wrap"); grant_begin("wr_wrap", 32'h2000, 8'd3, 1'b0); write_beats("wr_wrap", 4);
    ci_rd(3'd5, r);
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL wr_wrap_status: got %h expected 0", r); end
  endtask

  task automatic test_write_stall();
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hC0 + 32'(i);
    wexp[0] = 32'hC0; wexp[1] = 32'hC1; wexp[2] = 32'hC1; wexp[3] = 32'hC1;
    wexp[4] = 32'hC1; wexp[5] = 32'hC2; wexp[6] = 32'hC3;
    wbusy[0] = 1'b0; wbusy[1] = 1'b1; wbusy[2] = 1'b1; wbusy[3] = 1'b1;
    wbusy[4] = 1'b0; wbusy[5] = 1'b0; wbusy[6] = 1'b0;
    config_xfer(32'h3000, 32'd16, 32'd4, 32'd3, 32'd2);
    wait_request("stall"); grant_begin("stall", 32'h3000, 8'd3, 1'b0); write_beats("stall", 7);
  endtask

  task automatic test_short_last_burst();
    config_xfer(32'h4000, 32'd100, 32'd5, 32'd3, 32'd1);
    wait_request("sh_b1"); grant_begin("sh_b1", 32'h4000, 8'd3, 1'b1); read_beats("sh_b1", 9'd100, 32'hD0, 4);
    wait_request("sh_b2"); grant_begin("sh_b2", 32'h4010, 8'd0, 1'b1); read_beats("sh_b2", 9'd104, 32'hD4, 1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem[100 + i] !== 32'hD0 + 32'(i)) begin fails++; $display("FAIL sh_ram%0d: got %h expected %h", 100 + i, mem[100 + i], 32'hD0 + 32'(i)); end
    end
  endtask

  task automatic test_bus_error();
    logic [31:0] r;
    config_xfer(32'h5000, 32'd200, 32'd4, 32'd3, 32'd1);
    wait_request("err"); grant_begin("err", 32'h5000, 8'd3, 1'b1);
    cyc(); busDataValidIn = 1'b1; busDataIn = 32'hE0;
    cyc(); busDataIn = 32'hE1; busErrorIn = 1'b1;
    sample();
    checks++; if (busRequest !== 1'b1) begin fails++; $display("FAIL err_same_cycle_req: got %0b expected 1", busRequest); end
    cyc(); busDataValidIn = 1'b0; busDataIn = '0; busErrorIn = 1'b0;
    sample();
    checks++; if (busRequest !== 1'b0 || busByteEnables !== 4'h0 || busReadNotWrite !== 1'b0) begin
      fails++; $display("FAIL err_release: got req=%0b be=%h rnw=%0b expected 0", busRequest, busByteEnables, busReadNotWrite); end
    ci_rd(3'd5, r);
    checks++; if (r !== 32'h2) begin fails++; $display("FAIL err_status: got %h expected 2", r); end
    ci_wr(3'd5, 32'd0); ci_rd(3'd5, r);
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL err_clear: got %h expected 0", r); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] r;
    int seen;
    config_xfer(32'h6000, 32'd300, 32'd4, 32'd3, 32'd1);
    wait_request("mrst"); grant_begin("mrst", 32'h6000, 8'd3, 1'b1);
    cyc(); busDataValidIn = 1'b1; busDataIn = 32'hF0;
    cyc(); busDataIn = 32'hF1; reset = 1'b1;
    #1;
    checks++; if (busRequest !== 1'b0 || ramWriteEnable !== 1'b0 || ramWriteData !== 32'd0 || ramAddress !== 9'd0) begin
      fails++; $display("FAIL mrst_ram: got req=%0b we=%0b d=%h a=%0d expected 0", busRequest, ramWriteEnable, ramWriteData, ramAddress); end
    checks++; if (busByteEnables !== 4'h0 || busReadNotWrite !== 1'b0 || busAddressData !== 32'd0 || busDataValid !== 1'b0) begin
      fails++; $display("FAIL mrst_bus: got be=%h rnw=%0b ad=%h v=%0b expected 0", busByteEnables, busReadNotWrite, busAddressData, busDataValid); end
    cyc(); reset = 1'b0; busDataValidIn = 1'b0; busDataIn = '0;
    ci_rd(3'd5, r);
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL mrst_status: got %h expected 0", r); end
    ci_rd(3'd1, r);
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL mrst_busaddr: got %h expected 0", r); end
    ci_wr(3'd5, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin cyc(); sample(); if (busRequest !== 1'b0) seen++; end
    checks++; if (seen !== 0) begin fails++; $display("FAIL size0_no_request: got %0d request cycles expected 0", seen); end
    ci_rd(3'd5, r);
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL size0_status: got %h expected 0", r); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; valueA = '0; valueB = '0; ciN = '0;
    busGrant = 1'b0; busDataIn = '0; busDataValidIn = 1'b0; busBusyIn = 1'b0;
    busErrorIn = 1'b0; busEndTransactionIn = 1'b0;
    test_reset();
    test_registers();
    test_bus_to_ram();
    test_ram_to_bus_wrap();
    test_write_stall();
    test_short_last_burst();
    test_bus_error();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
